// File: rtl/load_store_unit.sv
// Load/store controller in front of a level-sensitive byte memory: checks alignment,
// opens exactly one stable enable window per access and returns a registered response.
module load_store_unit #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [7:0]       req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_error,
    output logic             mem_enable,
    output logic             mem_read_write,
    output logic [1:0]       mem_size,
    output logic             mem_sign_extend,
    output logic [7:0]       mem_address,
    output logic [31:0]      mem_data_in,
    input  logic [31:0]      mem_data_out,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] error_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam int                WAIT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_req_ready;
    logic              w_resp_valid;
    logic              w_accept;
    logic              w_misaligned;
    logic              w_enter_resp;
    logic              w_next_access;

    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [7:0]        r_addr;
    logic [31:0]       r_wdata;
    logic [WAIT_W-1:0] r_wait;
    logic [31:0]       r_rdata;
    logic              r_error;
    logic              r_mem_enable;
    logic              r_mem_rw;
    logic [CNT_W-1:0]  r_load_count;
    logic [CNT_W-1:0]  r_store_count;
    logic [CNT_W-1:0]  r_error_count;

    assign w_misaligned = (req_size == 2'b11)
                        | ((req_size == 2'b01) & req_addr[0])
                        | ((req_size == 2'b10) & (|req_addr[1:0]));

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) w_next_state = w_misaligned ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (r_wait == '0) w_next_state = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                if (resp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept      = req_valid & w_req_ready;
    assign w_enter_resp  = (r_state != S_RESP) && (w_next_state == S_RESP);
    assign w_next_access = (w_next_state == S_ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every register here uses <= so all updates see the same pre-edge values;
    // mixing in blocking assignments would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write       <= 1'b0;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wait        <= '0;
            r_rdata       <= '0;
            r_error       <= 1'b0;
            r_mem_enable  <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_load_count  <= '0;
            r_store_count <= '0;
            r_error_count <= '0;
        end else begin
            // Enable/write strobes come straight from flops so they cannot glitch.
            r_mem_enable <= w_next_access;
            r_mem_rw     <= w_next_access & (w_accept ? req_write : r_write);

            if (w_accept) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_wait   <= WAIT_LOAD;
                r_rdata  <= '0;
                r_error  <= w_misaligned;
            end else if (r_state == S_ACCESS) begin
                if (r_wait == '0) begin
                    if (!r_write) r_rdata <= mem_data_out;
                end else begin
                    r_wait <= r_wait - WAIT_W'(1);
                end
            end

            if (w_enter_resp) begin
                if (w_accept) begin
                    if (r_error_count != '1) r_error_count <= r_error_count + CNT_W'(1);
                end else if (r_write) begin
                    if (r_store_count != '1) r_store_count <= r_store_count + CNT_W'(1);
                end else begin
                    if (r_load_count != '1) r_load_count <= r_load_count + CNT_W'(1);
                end
            end
        end
    end

    assign req_ready       = w_req_ready;
    assign resp_valid      = w_resp_valid;
    assign resp_rdata      = r_rdata;
    assign resp_error      = r_error;
    assign mem_enable      = r_mem_enable;
    assign mem_read_write  = r_mem_rw;
    assign mem_size        = r_size;
    assign mem_sign_extend = r_signed;
    assign mem_address     = r_addr;
    assign mem_data_in     = r_wdata;
    assign load_count      = r_load_count;
    assign store_count     = r_store_count;
    assign error_count     = r_error_count;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a MEM_WAIT=1 unit with a big-endian byte memory and a
// MEM_WAIT=3 / 2-bit-counter unit with a fixed-pattern memory, muxed onto one driver.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        mem_clear;
    logic        req_valid, req_write, req_signed, resp_ready;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;

    logic        a_req_ready, a_resp_valid, a_resp_error, a_mem_enable, a_mem_rw, a_mem_se;
    logic [31:0] a_resp_rdata, a_mem_din, a_mem_dout;
    logic [1:0]  a_mem_size;
    logic [7:0]  a_mem_addr;
    logic [15:0] a_load_cnt, a_store_cnt, a_err_cnt;

    logic        b_req_ready, b_resp_valid, b_resp_error, b_mem_enable, b_mem_rw, b_mem_se;
    logic [31:0] b_resp_rdata, b_mem_din, b_mem_dout;
    logic [1:0]  b_mem_size;
    logic [7:0]  b_mem_addr;
    logic [1:0]  b_load_cnt, b_store_cnt, b_err_cnt;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WAIT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
        .resp_rdata(a_resp_rdata), .resp_error(a_resp_error),
        .mem_enable(a_mem_enable), .mem_read_write(a_mem_rw), .mem_size(a_mem_size),
        .mem_sign_extend(a_mem_se), .mem_address(a_mem_addr), .mem_data_in(a_mem_din),
        .mem_data_out(a_mem_dout),
        .load_count(a_load_cnt), .store_count(a_store_cnt), .error_count(a_err_cnt)
    );

    load_store_unit #(.MEM_WAIT(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error),
        .mem_enable(b_mem_enable), .mem_read_write(b_mem_rw), .mem_size(b_mem_size),
        .mem_sign_extend(b_mem_se), .mem_address(b_mem_addr), .mem_data_in(b_mem_din),
        .mem_data_out(b_mem_dout),
        .load_count(b_load_cnt), .store_count(b_store_cnt), .error_count(b_err_cnt)
    );

    // Observed view of whichever unit is selected.
    wire        req_ready  = sel ? b_req_ready  : a_req_ready;
    wire        resp_valid = sel ? b_resp_valid : a_resp_valid;
    wire        resp_error = sel ? b_resp_error : a_resp_error;
    wire [31:0] resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
    wire        mem_en     = sel ? b_mem_enable : a_mem_enable;
    wire        mem_rw     = sel ? b_mem_rw     : a_mem_rw;
    wire        mem_se     = sel ? b_mem_se     : a_mem_se;
    wire [1:0]  mem_size   = sel ? b_mem_size   : a_mem_size;
    wire [7:0]  mem_addr   = sel ? b_mem_addr   : a_mem_addr;
    wire [31:0] mem_din    = sel ? b_mem_din    : a_mem_din;
    wire [15:0] load_cnt   = sel ? {14'd0, b_load_cnt}  : a_load_cnt;
    wire [15:0] store_cnt  = sel ? {14'd0, b_store_cnt} : a_store_cnt;
    wire [15:0] err_cnt    = sel ? {14'd0, b_err_cnt}   : a_err_cnt;

    // Level-sensitive RAM stand-in for unit A: writes every cycle Enable & ReadWrite are high.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (a_mem_enable && a_mem_rw) begin
            case (a_mem_size)
                2'b00: ram[a_mem_addr] <= a_mem_din[7:0];
                2'b01: begin
                    ram[a_mem_addr]         <= a_mem_din[15:8];
                    ram[8'(a_mem_addr + 1)] <= a_mem_din[7:0];
                end
                2'b10: begin
                    ram[a_mem_addr]         <= a_mem_din[31:24];
                    ram[8'(a_mem_addr + 1)] <= a_mem_din[23:16];
                    ram[8'(a_mem_addr + 2)] <= a_mem_din[15:8];
                    ram[8'(a_mem_addr + 3)] <= a_mem_din[7:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        a_mem_dout = 32'h0;
        case (a_mem_size)
            2'b00: a_mem_dout = {{24{a_mem_se & ram[a_mem_addr][7]}}, ram[a_mem_addr]};
            2'b01: a_mem_dout = {{16{a_mem_se & ram[a_mem_addr][7]}}, ram[a_mem_addr],
                                 ram[8'(a_mem_addr + 1)]};
            2'b10: a_mem_dout = {ram[a_mem_addr], ram[8'(a_mem_addr + 1)],
                                 ram[8'(a_mem_addr + 2)], ram[8'(a_mem_addr + 3)]};
            default: a_mem_dout = 32'h0;
        endcase
    end

    assign b_mem_dout = {4{b_mem_addr}};

    // Reference model: byte image of memory A and per-unit counter expectations.
    logic [7:0] model_mem [256];
    int         exp_cnt [2][3];   // [unit][0=load,1=store,2=error]
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] ad, input int nb, input logic sg);
        longint v = 0;
        for (int i = 0; i < nb; i++) v = v * 256 + longint'(model_mem[8'(ad + i)]);
        if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    task automatic bump(input int unit, input int kind);
        int max = (unit == 1) ? 3 : 65535;
        if (exp_cnt[unit][kind] < max) exp_cnt[unit][kind]++;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [7:0] ad, input logic [31:0] wd, input int hold);
        int          unit = sel ? 1 : 0;
        int          mw   = sel ? 3 : 1;
        int          nb   = (sz == 2'b11) ? 1 : (1 << sz);
        logic        err  = (sz == 2'b11) || ((int'(ad) % nb) != 0);
        logic [31:0] exp_rd;
        int          lat = 0;
        int          en  = 0;
        if (err || w)  exp_rd = 32'h0;
        else if (sel)  exp_rd = {4{ad}};
        else           exp_rd = ref_load(ad, nb, sg);

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 8'($urandom); req_wdata = $urandom;
        req_size = 2'($urandom); req_write = 1'($urandom); req_signed = 1'($urandom);

        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_en) begin
                en++;
                check("win_rw",   32'(mem_rw),   32'(w));
                check("win_addr", 32'(mem_addr), 32'(ad));
                check("win_size", 32'(mem_size), 32'(sz));
                check("win_se",   32'(mem_se),   32'(sg));
                if (w) check("win_din", mem_din, wd);
            end
            if (resp_valid) break;
        end
        check("latency",    lat, err ? 32'd1 : 32'(mw + 1));
        check("en_cycles",  en,  err ? 32'd0 : 32'(mw));
        check("resp_error", 32'(resp_error), 32'(err));
        check("resp_rdata", resp_rdata, exp_rd);
        check("ready_busy", 32'(req_ready), 32'd0);
        check("mem_en_off", 32'(mem_en), 32'd0);

        if (!err && w && !sel)
            for (int i = 0; i < nb; i++) model_mem[8'(ad + i)] = 8'(wd >> (8 * (nb - 1 - i)));
        bump(unit, err ? 2 : (w ? 1 : 0));
        check("load_count",  32'(load_cnt),  32'(exp_cnt[unit][0]));
        check("store_count", 32'(store_cnt), 32'(exp_cnt[unit][1]));
        check("error_count", 32'(err_cnt),   32'(exp_cnt[unit][2]));

        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_error", 32'(resp_error), 32'(err));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic check_ram(input string tag);
        int mism = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) mism++;
        check(tag, mism, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_clear = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0; resp_ready = 1'b0;
        req_size = 2'b00; req_addr = 8'h00; req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        for (int u = 0; u < 2; u++) for (int k = 0; k < 3; k++) exp_cnt[u][k] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  32'(a_req_ready),  32'd1);
        check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_mem_en",     32'(a_mem_enable), 32'd0);
        check("rst_mem_addr",   32'(a_mem_addr),   32'd0);
        check("rst_rdata",      a_resp_rdata,      32'd0);
        check("rst_counts",     32'(a_load_cnt | a_store_cnt | a_err_cnt), 32'd0);
        rst_n = 1'b1; mem_clear = 1'b0;

        // Directed: big-endian word, byte/half views, sign extension.
        do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344, 0);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0);
        do_req(1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 0);
        do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 1);
        do_req(1'b1, 2'b00, 1'b0, 8'h20, 32'h00000080, 0);
        do_req(1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 0);
        do_req(1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 0);
        check("dir_word_byte0", 32'(ram[8'h10]), 32'h11);

        // Misaligned and illegal size: no access, memory untouched.
        do_req(1'b0, 2'b10, 1'b0, 8'h06, 32'h0, 0);
        do_req(1'b1, 2'b01, 1'b0, 8'h03, 32'hDEADBEEF, 0);
        do_req(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 0);
        check("err_count_3", 32'(a_err_cnt), 32'd3);
        check_ram("ram_after_errors");

        // Randomized traffic over a small window so loads hit earlier stores.
        for (int n = 0; n < 150; n++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 31)),
                   $urandom, int'($urandom_range(0, 2)));
        check_ram("ram_after_random");

        // Unit B: 3-cycle window, 5-cycle stall, 2-bit counter saturation.
        sel = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 8'h44, 32'h0, 5);
        for (int n = 0; n < 3; n++) do_req(1'b0, 2'b10, 1'b1, 8'(8'h80 + 4 * n), 32'h0, n);
        check("b_load_sat", 32'(b_load_cnt), 32'd3);

        // Reset in the middle of a B access window.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 8'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_en", 32'(b_mem_enable), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_en",    32'(b_mem_enable), 32'd0);
        check("rst_mid_valid", 32'(b_resp_valid), 32'd0);
        check("rst_mid_cnt",   32'(b_load_cnt | a_load_cnt | a_store_cnt | a_err_cnt), 32'd0);
        for (int u = 0; u < 2; u++) for (int k = 0; k < 3; k++) exp_cnt[u][k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale_valid", 32'(b_resp_valid), 32'd0);
            check("no_stale_en",    32'(b_mem_enable), 32'd0);
            check("ready_after",    32'(b_req_ready),  32'd1);
        end

        // Both units still work after reset.
        do_req(1'b0, 2'b10, 1'b0, 8'h48, 32'h0, 0);
        sel = 1'b0;
        do_req(1'b1, 2'b01, 1'b0, 8'h30, 32'h0000A5C3, 0);
        do_req(1'b0, 2'b01, 1'b1, 8'h30, 32'h0, 0);
        check_ram("ram_final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
